// File: rtl/top.sv
// top: 8-bit counter stepped by SW on each prescaler tick, shown as two hex digits on a multiplexed 7-segment display.
// Define SIM_FAST_CLK_EN to force a 4-bit prescaler and 2-bit mux divider for fast simulation.
module top #(
    parameter int PRESCALE_BITS = 24,
    parameter int MUX_BITS = 10
) (
    input logic CLK,
    input logic RST_N,
    input logic [3:0] SW,
    output logic LED_USER,
    output logic [6:0] ssd_anode,
    output logic ssd_cathode
);
`ifdef SIM_FAST_CLK_EN
    localparam int PB = 4;
    localparam int MB = 2;
`else
    localparam int PB = PRESCALE_BITS;
    localparam int MB = MUX_BITS;
`endif
    logic [PB-1:0] pre;
    logic [MB-1:0] mux;
    logic [7:0] count;
    logic sel;
    logic tick;
    logic mux_wrap;
    logic [3:0] nib;
    logic [6:0] seg;
    assign tick = &pre;
    assign mux_wrap = &mux;
    assign nib = sel ? count[7:4] : count[3:0];
    always_comb begin
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
    end
    // SW reaches only count, so no combinational path exists from SW to the pins
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pre <= '0;
            mux <= '0;
            count <= 8'd0;
            sel <= 1'b0;
            LED_USER <= 1'b0;
            ssd_anode <= 7'h3F;
            ssd_cathode <= 1'b0;
        end else begin
            pre <= pre + 1'b1;
            mux <= mux + 1'b1;
            count <= tick ? count + {4'd0, SW} : count;
            LED_USER <= LED_USER ^ tick;
            sel <= sel ^ mux_wrap;
            ssd_anode <= seg;
            ssd_cathode <= sel;
        end
    end
endmodule

// File: tb/tb_top.sv
// tb_top: table-driven and scoreboard check of top with a 4-bit prescaler and 2-bit mux divider.
module tb_top;
    logic tb_clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] sw = 4'd0;
    logic led_user;
    logic [6:0] ssd_anode;
    logic ssd_cathode;

    top #(.PRESCALE_BITS(4), .MUX_BITS(2)) dut (
        .CLK(tb_clk),
        .RST_N(rst_n),
        .SW(sw),
        .LED_USER(led_user),
        .ssd_anode(ssd_anode),
        .ssd_cathode(ssd_cathode)
    );

    always #5 tb_clk = ~tb_clk;

    typedef struct {
        logic [6:0] an;
        logic cat;
        logic led;
    } exp_t;

    typedef struct {
        logic [3:0] sw;
        int cycles;
        logic [7:0] exp_cnt;
        logic exp_led;
    } vec_t;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int m_cyc = 0;
    logic [7:0] m_cnt = 8'd0;
    logic m_sel = 1'b0;
    logic m_led = 1'b0;
    logic rec = 1'b0;
    logic [6:0] lo_seen, hi_seen;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: push the expected pins for this edge, drive, then pop and compare at the falling edge
    task automatic cycle(input logic r, input logic [3:0] s);
        exp_t e;
        exp_t g;
        rst_n = r;
        sw = s;
        if (!r) begin
            e = '{7'h3F, 1'b0, 1'b0};
            m_cyc = 0;
            m_cnt = 8'd0;
            m_sel = 1'b0;
            m_led = 1'b0;
        end else begin
            e.an = seg_tab[m_sel ? m_cnt[7:4] : m_cnt[3:0]];
            e.cat = m_sel;
            if (m_cyc % 16 == 15) begin
                m_cnt = m_cnt + {4'd0, s};
                m_led = ~m_led;
            end
            if (m_cyc % 4 == 3) m_sel = ~m_sel;
            e.led = m_led;
            m_cyc++;
        end
        q.push_back(e);
        @(negedge tb_clk);
        g = q.pop_front();
        check("anode", {1'b0, ssd_anode}, {1'b0, g.an});
        check("cathode", {7'd0, ssd_cathode}, {7'd0, g.cat});
        check("led", {7'd0, led_user}, {7'd0, g.led});
        if (rec) begin
            if (ssd_cathode) hi_seen = ssd_anode;
            else lo_seen = ssd_anode;
        end
    endtask

    task automatic do_reset();
        repeat (2) cycle(1'b0, 4'd0);
    endtask

    // Eight quiet clocks cover both digits, then the captured patterns must spell exp
    task automatic settle(input string name, input logic [7:0] exp);
        lo_seen = 7'h00;
        hi_seen = 7'h00;
        rec = 1'b1;
        repeat (8) cycle(1'b1, 4'd0);
        rec = 1'b0;
        check({name, "_lo"}, {1'b0, lo_seen}, {1'b0, seg_tab[exp[3:0]]});
        check({name, "_hi"}, {1'b0, hi_seen}, {1'b0, seg_tab[exp[7:4]]});
    endtask

    initial begin
        vec_t vecs [6];
        logic [7:0] exp_sum;
        logic [3:0] s;
        vecs[0] = '{4'd1, 160, 8'h0A, 1'b0};
        vecs[1] = '{4'd15, 272, 8'hFF, 1'b1};
        vecs[2] = '{4'd15, 288, 8'h0E, 1'b0};
        vecs[3] = '{4'd0, 80, 8'h00, 1'b1};
        vecs[4] = '{4'd3, 48, 8'h09, 1'b1};
        vecs[5] = '{4'd9, 64, 8'h24, 1'b0};
        @(negedge tb_clk);
        do_reset();
        check("reset_anode", {1'b0, ssd_anode}, 8'h3F);
        check("reset_cathode", {7'd0, ssd_cathode}, 8'd0);
        check("reset_led", {7'd0, led_user}, 8'd0);
        for (int i = 0; i < 6; i++) begin
            do_reset();
            repeat (vecs[i].cycles) cycle(1'b1, vecs[i].sw);
            check($sformatf("row%0d_led", i), {7'd0, led_user}, {7'd0, vecs[i].exp_led});
            settle($sformatf("row%0d_cnt", i), vecs[i].exp_cnt);
        end
        do_reset();
        for (int k = 1; k <= 64; k++)
            cycle(1'b1, (k % 16 >= 5 && k % 16 <= 7) ? 4'd7 : 4'd0);
        check("pulse_led", {7'd0, led_user}, 8'd0);
        settle("pulse_cnt", 8'h00);
        do_reset();
        exp_sum = 8'd0;
        for (int k = 1; k <= 170; k++) begin
            s = (((k - 1) / 10) % 2 == 0) ? 4'd15 : 4'd0;
            if (k % 16 == 0) exp_sum = exp_sum + {4'd0, s};
            cycle(1'b1, s);
        end
        settle("step_cnt", exp_sum);
        do_reset();
        repeat (40) cycle(1'b1, 4'd1);
        cycle(1'b0, 4'd1);
        check("midrst_anode", {1'b0, ssd_anode}, 8'h3F);
        check("midrst_cathode", {7'd0, ssd_cathode}, 8'd0);
        check("midrst_led", {7'd0, led_user}, 8'd0);
        repeat (15) cycle(1'b1, 4'd1);
        check("midrst_notick", {7'd0, led_user}, 8'd0);
        cycle(1'b1, 4'd1);
        check("midrst_tick", {7'd0, led_user}, 8'd1);
        settle("midrst_cnt", 8'h01);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
